// File: rtl/wb_ram_if.sv
// Wishbone B4 slave-side bus bundle for wb_ram: request lines from the master, registered response from the RAM.
// CTI_I only matters when the RAM is built with WB_RAM_BURST_EN.
interface wb_ram_if #(
  parameter int unsigned ADR_WIDTH = 10,
  parameter int unsigned DAT_WIDTH = 32
);
  logic                   CYC_I;
  logic                   STB_I;
  logic                   WE_I;
  logic [ADR_WIDTH-1:0]   ADR_I;
  logic [DAT_WIDTH/8-1:0] SEL_I;
  logic [DAT_WIDTH-1:0]   DAT_I;
  logic [2:0]             CTI_I;
  logic [DAT_WIDTH-1:0]   DAT_O;
  logic                   ACK_O;
  logic                   ERR_O;

  modport master (
    output CYC_I, STB_I, WE_I, ADR_I, SEL_I, DAT_I, CTI_I,
    input  DAT_O, ACK_O, ERR_O
  );

  modport slave (
    input  CYC_I, STB_I, WE_I, ADR_I, SEL_I, DAT_I, CTI_I,
    output DAT_O, ACK_O, ERR_O
  );
endinterface

// File: rtl/wb_ram.sv
// Wishbone byte-lane RAM; incrementing bursts are compiled in only with `define WB_RAM_BURST_EN.
// Latency: first ACK/ERR WAIT_STATES+1 cycles after the request, then one beat per cycle within a burst.
// Backpressure: no stalls beyond the wait states; CYC/STB dropping during the wait aborts without side effects.
module wb_ram #(
  parameter int unsigned ADR_WIDTH   = 10,
  parameter int unsigned DAT_WIDTH   = 32,
  parameter int unsigned DEPTH       = 256,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic    CLK_I,
  input  logic    RST_I,
  wb_ram_if.slave wb
);

  localparam int unsigned NB  = DAT_WIDTH / 8;
  localparam int unsigned LSB = (NB > 1) ? $clog2(NB) : 0;
  localparam int unsigned IW  = ADR_WIDTH - LSB;
  localparam int unsigned AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [2:0]           cnt_q, cnt_d;
  logic                 ack_q, ack_d;
  logic                 err_q, err_d;
  logic [DAT_WIDTH-1:0] dat_q, dat_d;

  logic [DAT_WIDTH-1:0] mem [DEPTH];

  logic                 req;
  logic                 access;
  logic                 oor;
  logic                 wr_en;
  logic [IW:0]          acc_idx;
  logic [AW-1:0]        mem_idx;
  logic [DAT_WIDTH-1:0] rd_word;
  logic                 unused_ok;

`ifdef WB_RAM_BURST_EN
  logic                 cont_q, cont_d;
  logic [IW-1:0]        cur_q, cur_d;
`endif

  assign req       = wb.CYC_I & wb.STB_I;
  assign unused_ok = ^wb.ADR_I ^ ^wb.CTI_I;

  // Word index of the beat being served: bus address, or the running burst index.
  always_comb begin
    acc_idx = {1'b0, wb.ADR_I[ADR_WIDTH-1:LSB]};
`ifdef WB_RAM_BURST_EN
    if (state_q == RESP) begin
      acc_idx = {1'b0, cur_q} + {{IW{1'b0}}, 1'b1};
    end
`endif
  end

  assign oor     = 32'(acc_idx) >= DEPTH;
  assign mem_idx = AW'(acc_idx);
  assign rd_word = mem[mem_idx];
  assign wr_en   = access & wb.WE_I & ~oor & ~RST_I;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    dat_d   = dat_q;
    access  = 1'b0;
`ifdef WB_RAM_BURST_EN
    cont_d  = 1'b0;
    cur_d   = cur_q;
`endif

    case (state_q)
      IDLE: begin
        if (req) begin
          if (WAIT_STATES == 0) begin
            access = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = 3'(WAIT_STATES);
          end
        end
      end
      WAIT: begin
        if (!req) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - 3'd1;
          if (cnt_q <= 3'd1) begin
            access = 1'b1;
          end
        end
      end
      RESP: begin
        state_d = IDLE;
`ifdef WB_RAM_BURST_EN
        if (cont_q && req) begin
          access = 1'b1;
        end
`endif
      end
      default: state_d = IDLE;
    endcase

    // Capture happens on the edge that enters (or stays in) RESP.
    if (access) begin
      state_d = RESP;
      cnt_d   = '0;
      if (oor) begin
        err_d = 1'b1;
      end else begin
        ack_d = 1'b1;
        if (!wb.WE_I) begin
          for (int b = 0; b < NB; b++) begin
            dat_d[8*b +: 8] = wb.SEL_I[b] ? rd_word[8*b +: 8] : 8'h00;
          end
        end
      end
`ifdef WB_RAM_BURST_EN
      cont_d = (wb.CTI_I == 3'b010) && !oor;
      cur_d  = acc_idx[IW-1:0];
`endif
    end
  end

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      dat_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      dat_q   <= dat_d;
    end
  end

`ifdef WB_RAM_BURST_EN
  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      cont_q <= 1'b0;
      cur_q  <= '0;
    end else begin
      cont_q <= cont_d;
      cur_q  <= cur_d;
    end
  end
`endif

  // Storage has no reset so contents survive RST_I.
  always_ff @(posedge CLK_I) begin
    if (wr_en) begin
      for (int b = 0; b < NB; b++) begin
        if (wb.SEL_I[b]) begin
          mem[mem_idx][8*b +: 8] <= wb.DAT_I[8*b +: 8];
        end
      end
    end
  end

  assign wb.DAT_O = dat_q;
  assign wb.ACK_O = ack_q;
  assign wb.ERR_O = err_q;

endmodule

// File: tb/tb_wb_ram.sv
// Scoreboard bench for wb_ram: a main instance with default wait states and a second one with WAIT_STATES=3.
// The burst sequence is exercised only when WB_RAM_BURST_EN is defined.
module tb_wb_ram;

  localparam int DEPTH = 256;
  localparam int WS    = 1;
  localparam int WS3   = 3;

  typedef struct {
    logic        err;
    logic [31:0] dat;
    int          lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  wb_ram_if #(.ADR_WIDTH(12), .DAT_WIDTH(32)) bus  ();
  wb_ram_if #(.ADR_WIDTH(12), .DAT_WIDTH(32)) bus3 ();

  wb_ram #(.ADR_WIDTH(12), .DAT_WIDTH(32), .DEPTH(DEPTH), .WAIT_STATES(WS)) u_dut (
    .CLK_I (clk),
    .RST_I (rst),
    .wb    (bus)
  );

  wb_ram #(.ADR_WIDTH(12), .DAT_WIDTH(32), .DEPTH(DEPTH), .WAIT_STATES(WS3)) u_dut_ws3 (
    .CLK_I (clk),
    .RST_I (rst),
    .wb    (bus3)
  );

  exp_t        sb_q[$];
  logic [31:0] mdl [DEPTH];
  logic [31:0] exp_dat_o;
  int          n_vec = 0;
  int          n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] lane_mask(input logic [31:0] w, input logic [3:0] s);
    logic [31:0] r;
    r = '0;
    for (int b = 0; b < 4; b++) begin
      if (s[b]) r[8*b +: 8] = w[8*b +: 8];
    end
    return r;
  endfunction

  task automatic idle_bus();
    bus.CYC_I = 1'b0; bus.STB_I = 1'b0; bus.WE_I = 1'b0;
    bus.ADR_I = '0;   bus.SEL_I = '0;   bus.DAT_I = '0; bus.CTI_I = '0;
  endtask

  task automatic idle_bus3();
    bus3.CYC_I = 1'b0; bus3.STB_I = 1'b0; bus3.WE_I = 1'b0;
    bus3.ADR_I = '0;   bus3.SEL_I = '0;   bus3.DAT_I = '0; bus3.CTI_I = '0;
  endtask

  // Single access on the main bus; expectation is queued before the request is driven.
  task automatic wb_xfer(input logic we, input logic [11:0] adr, input logic [3:0] sel,
                         input logic [31:0] dat, input logic [2:0] cti);
    exp_t e;
    int   idx;
    int   cyc;
    bit   got;
    idx   = int'(adr[11:2]);
    e.err = (idx >= DEPTH);
    e.lat = WS + 1;
    e.dat = exp_dat_o;
    if (!e.err) begin
      if (we) begin
        for (int b = 0; b < 4; b++) if (sel[b]) mdl[idx][8*b +: 8] = dat[8*b +: 8];
      end else begin
        e.dat = lane_mask(mdl[idx], sel);
      end
    end
    exp_dat_o = e.dat;
    sb_q.push_back(e);

    @(posedge clk); #1;
    bus.CYC_I = 1'b1; bus.STB_I = 1'b1; bus.WE_I = we;
    bus.ADR_I = adr;  bus.SEL_I = sel;  bus.DAT_I = dat; bus.CTI_I = cti;
    cyc = 0;
    got = 0;
    while (!got && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
      if (bus.ACK_O || bus.ERR_O) got = 1;
    end
    idle_bus();
    e = sb_q.pop_front();
    if (!got) begin
      chk("xfer_timeout", 32'(cyc), 32'(e.lat));
    end else begin
      chk("xfer_lat", 32'(cyc), 32'(e.lat));
      chk("xfer_ack", 32'(bus.ACK_O), 32'(!e.err));
      chk("xfer_err", 32'(bus.ERR_O), 32'(e.err));
      chk("xfer_dat", bus.DAT_O, e.dat);
      @(posedge clk); #1;
      chk("xfer_pulse", 32'({bus.ACK_O, bus.ERR_O}), 32'd0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [11:0] a;
    logic [31:0] w;
    exp_t        e;
    int          cyc;
    bit          got;

    for (int i = 0; i < DEPTH; i++) mdl[i] = '0;
    exp_dat_o = '0;
    idle_bus();
    idle_bus3();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ack", 32'(bus.ACK_O), 32'd0);
    chk("rst_err", 32'(bus.ERR_O), 32'd0);
    chk("rst_dat", bus.DAT_O, 32'd0);
    rst = 1'b0;

    wb_xfer(1'b0, 12'h000, 4'hF, 32'h0, 3'b000);
    wb_xfer(1'b1, 12'h010, 4'b0101, 32'hDEADBEEF, 3'b000);
    wb_xfer(1'b0, 12'h010, 4'hF, 32'h0, 3'b000);
    wb_xfer(1'b0, 12'h013, 4'b1100, 32'h0, 3'b000);

    for (int i = 0; i < 8; i++) begin
      a = {2'b00, 8'($urandom_range(8, 255)), 2'b00};
      w = $urandom;
      wb_xfer(1'b1, a, 4'hF, w, 3'b000);
      wb_xfer(1'b0, a, 4'($urandom_range(1, 15)), 32'h0, 3'b000);
    end

    wb_xfer(1'b1, 12'h010, 4'h0, 32'hFFFFFFFF, 3'b000);
    wb_xfer(1'b0, 12'h010, 4'hF, 32'h0, 3'b000);
    wb_xfer(1'b1, 12'h3FC, 4'hF, 32'h5A5A0001, 3'b000);
    wb_xfer(1'b0, 12'h3FC, 4'hF, 32'h0, 3'b000);

    // Out-of-range accesses must not alias onto low words.
    wb_xfer(1'b0, 12'h400, 4'hF, 32'h0, 3'b000);
    wb_xfer(1'b1, 12'h400, 4'hF, 32'hCAFEF00D, 3'b000);
    wb_xfer(1'b1, 12'hFFC, 4'hF, 32'hCAFEF00D, 3'b000);
    wb_xfer(1'b0, 12'h000, 4'hF, 32'h0, 3'b000);
    wb_xfer(1'b0, 12'h3FC, 4'hF, 32'h0, 3'b000);

    wb_xfer(1'b0, 12'h010, 4'hF, 32'h0, 3'b010);

    // Reset landing in WAIT: outputs cleared, write dropped, FSM back in IDLE.
    @(posedge clk); #1;
    bus.CYC_I = 1'b1; bus.STB_I = 1'b1; bus.WE_I = 1'b1;
    bus.ADR_I = 12'h014; bus.SEL_I = 4'hF; bus.DAT_I = 32'hA5A5A5A5; bus.CTI_I = 3'b000;
    @(posedge clk); #1;
    chk("rstw_wait", 32'({bus.ACK_O, bus.ERR_O}), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rstw_ack", 32'(bus.ACK_O), 32'd0);
    chk("rstw_err", 32'(bus.ERR_O), 32'd0);
    chk("rstw_dat", bus.DAT_O, 32'd0);
    rst = 1'b0;
    idle_bus();
    exp_dat_o = '0;
    wb_xfer(1'b0, 12'h014, 4'hF, 32'h0, 3'b000);

`ifdef WB_RAM_BURST_EN
    for (int i = 0; i < 4; i++) wb_xfer(1'b1, 12'(i * 4), 4'hF, $urandom, 3'b000);
    for (int i = 0; i < 4; i++) begin
      e.err = 1'b0;
      e.dat = mdl[i];
      e.lat = WS + 1;
      sb_q.push_back(e);
    end
    exp_dat_o = mdl[3];
    @(posedge clk); #1;
    bus.CYC_I = 1'b1; bus.STB_I = 1'b1; bus.WE_I = 1'b0;
    bus.ADR_I = 12'h000; bus.SEL_I = 4'hF; bus.CTI_I = 3'b010;
    cyc = 0;
    got = 0;
    while (!got && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
      if (bus.ACK_O || bus.ERR_O) got = 1;
    end
    if (!got) begin
      chk("burst_timeout", 32'(cyc), 32'(WS + 1));
      sb_q.delete();
      idle_bus();
    end else begin
      chk("burst_lat", 32'(cyc), 32'(WS + 1));
      for (int b = 0; b < 4; b++) begin
        if (b > 0) begin
          @(posedge clk); #1;
        end
        e = sb_q.pop_front();
        chk("burst_ack", 32'(bus.ACK_O), 32'd1);
        chk("burst_dat", bus.DAT_O, e.dat);
        bus.ADR_I = 12'((b + 1) * 4);
        bus.CTI_I = (b == 2) ? 3'b111 : 3'b010;
        if (b == 3) idle_bus();
      end
      @(posedge clk); #1;
      chk("burst_end", 32'({bus.ACK_O, bus.ERR_O}), 32'd0);
    end
`endif

    // WAIT_STATES=3 instance: abort after two cycles, then a normal read.
    @(posedge clk); #1;
    bus3.CYC_I = 1'b1; bus3.STB_I = 1'b1; bus3.WE_I = 1'b1;
    bus3.ADR_I = 12'h020; bus3.SEL_I = 4'hF; bus3.DAT_I = 32'h12345678; bus3.CTI_I = 3'b000;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      chk("abort_wait", 32'({bus3.ACK_O, bus3.ERR_O}), 32'd0);
    end
    bus3.STB_I = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("abort_quiet", 32'({bus3.ACK_O, bus3.ERR_O}), 32'd0);
    end
    idle_bus3();
    @(posedge clk); #1;
    bus3.CYC_I = 1'b1; bus3.STB_I = 1'b1; bus3.WE_I = 1'b0;
    bus3.ADR_I = 12'h020; bus3.SEL_I = 4'hF;
    cyc = 0;
    got = 0;
    while (!got && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
      if (bus3.ACK_O || bus3.ERR_O) got = 1;
    end
    chk("ws3_lat", 32'(cyc), 32'(WS3 + 1));
    chk("ws3_ack", 32'(bus3.ACK_O), 32'd1);
    chk("ws3_dat", bus3.DAT_O, 32'd0);
    idle_bus3();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
